// File: rtl/fb_scan_controller.sv
// fb_scan_controller: double-buffered framebuffer read-side control.
// Maps scan coordinates to a read address in the shown bank and drives the
// ROM->RAM copier into the back bank. Banks swap only at frame boundaries.
// Optional copy watchdog: define FB_COPY_WATCHDOG_EN to enable it.
module fb_scan_controller #(
    parameter int IMG_W     = 160,
    parameter int IMG_H     = 120,
    parameter int SCR_W     = 640,
    parameter int SCR_H     = 480,
    parameter int ADDR_W    = 19,
    parameter int MAX_SHIFT = 2
`ifdef FB_COPY_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYC = 1048576
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [9:0]        i_next_x,
    input  logic [9:0]        i_next_y,
    input  logic              i_frame_start,
    input  logic [3:0]        i_mode,
    input  logic              i_copy_done,
    output logic              o_copy_start,
    output logic              o_copy_bank,
    output logic [3:0]        o_copy_mode,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_bank,
    output logic              o_pix_valid,
    output logic              o_busy,
    output logic              o_copy_err
);

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_COPY      = 2'd1,
        ST_SWAP_WAIT = 2'd2,
        ST_SHOW      = 2'd3
    } state_t;

    // Scaled image dimension: zoom multiplies, reduce divides, otherwise 1x.
    function automatic logic [ADDR_W-1:0] scale_dim(input logic is_zoom, input logic is_reduce,
                                                    input logic big_shift, input logic [ADDR_W-1:0] base);
        logic [ADDR_W-1:0] sh;
        logic [ADDR_W-1:0] res;
        sh = big_shift ? ADDR_W'(MAX_SHIFT) : ADDR_W'(1);
        if (is_zoom) begin
            res = base << sh;
        end else if (is_reduce) begin
            res = base >> sh;
        end else begin
            res = base;
        end
        return res;
    endfunction

    state_t            r_state;
    state_t            w_state_d;
    logic              r_show_bank;
    logic [3:0]        r_show_mode;
    logic              r_have;
    logic              r_pend;
    logic              r_mode_chg;
    logic [ADDR_W-1:0] r_w_disp, r_h_disp, r_xoff, r_yoff;

    logic              w_start, w_bank_d, w_swap, w_timeout;
    logic [3:0]        w_cmode_d;
    logic [3:0]        w_show_mode_d;
    logic              w_mode_ne_copy, w_pend_any;
    logic              w_new_zoom, w_new_reduce;
    logic [ADDR_W-1:0] w_new_w, w_new_h;

    assign w_mode_ne_copy = (i_mode != o_copy_mode);
    assign w_pend_any     = r_pend | w_mode_ne_copy;
    assign w_show_mode_d  = w_swap ? o_copy_mode : r_show_mode;

    // Geometry of the image about to be shown comes from the mode it was copied with.
    assign w_new_zoom   = ~o_copy_mode[2] & ~o_copy_mode[0];
    assign w_new_reduce = ~o_copy_mode[2] &  o_copy_mode[0];
    assign w_new_w = scale_dim(w_new_zoom, w_new_reduce, o_copy_mode[3], ADDR_W'(IMG_W));
    assign w_new_h = scale_dim(w_new_zoom, w_new_reduce, o_copy_mode[3], ADDR_W'(IMG_H));

`ifdef FB_COPY_WATCHDOG_EN
    localparam int DOG_W = $clog2(TIMEOUT_CYC + 1);
    logic [DOG_W-1:0] r_dog_cnt;
    logic             r_err;

    assign w_timeout  = (r_state == ST_COPY) && !i_copy_done && (r_dog_cnt == DOG_W'(TIMEOUT_CYC - 1));
    assign o_copy_err = r_err;

    // Watchdog counter: restarts with every copy_start, counts while copying; error is sticky.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dog_cnt <= {DOG_W{1'b0}};
            r_err     <= 1'b0;
        end else begin
            if (w_start) begin
                r_dog_cnt <= {DOG_W{1'b0}};
            end else if (r_state == ST_COPY) begin
                r_dog_cnt <= r_dog_cnt + DOG_W'(1);
            end else begin
                r_dog_cnt <= r_dog_cnt;
            end
            r_err <= r_err | w_timeout;
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign o_copy_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_BOOT: w_state_d = ST_COPY;
            ST_COPY: begin
                if (w_timeout) begin
                    w_state_d = ST_COPY;
                end else if (i_copy_done && !w_pend_any) begin
                    w_state_d = ST_SWAP_WAIT;
                end else begin
                    w_state_d = ST_COPY;
                end
            end
            ST_SWAP_WAIT: begin
                if (w_mode_ne_copy) begin
                    w_state_d = ST_COPY;
                end else if (i_frame_start) begin
                    w_state_d = ST_SHOW;
                end else begin
                    w_state_d = ST_SWAP_WAIT;
                end
            end
            ST_SHOW: begin
                if (r_mode_chg) begin
                    w_state_d = ST_COPY;
                end else begin
                    w_state_d = ST_SHOW;
                end
            end
            default: w_state_d = ST_BOOT;
        endcase
    end

    // FSM actions: copy launches (bank/mode) and the frame-aligned swap.
    always_comb begin
        w_start   = 1'b0;
        w_bank_d  = o_copy_bank;
        w_cmode_d = o_copy_mode;
        w_swap    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_start   = 1'b1;
                w_bank_d  = 1'b0;
                w_cmode_d = i_mode;
            end
            ST_COPY: begin
                if (w_timeout || (i_copy_done && w_pend_any)) begin
                    w_start   = 1'b1;
                    w_cmode_d = i_mode;
                end else begin
                    w_start   = 1'b0;
                end
            end
            ST_SWAP_WAIT: begin
                if (w_mode_ne_copy) begin
                    w_start   = 1'b1;
                    w_cmode_d = i_mode;
                end else if (i_frame_start) begin
                    w_swap = 1'b1;
                end else begin
                    w_swap = 1'b0;
                end
            end
            ST_SHOW: begin
                if (r_mode_chg) begin
                    w_start   = 1'b1;
                    w_bank_d  = ~r_show_bank;
                    w_cmode_d = i_mode;
                end else begin
                    w_start = 1'b0;
                end
            end
            default: w_start = 1'b0;
        endcase
    end

    // Copier outputs, shown-bank context and display geometry registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_copy_start <= 1'b0;
            o_copy_bank  <= 1'b0;
            o_copy_mode  <= 4'b0000;
            o_busy       <= 1'b0;
            r_show_bank  <= 1'b0;
            r_show_mode  <= 4'b0000;
            r_have       <= 1'b0;
            r_pend       <= 1'b0;
            r_mode_chg   <= 1'b0;
            r_w_disp     <= {ADDR_W{1'b0}};
            r_h_disp     <= {ADDR_W{1'b0}};
            r_xoff       <= {ADDR_W{1'b0}};
            r_yoff       <= {ADDR_W{1'b0}};
        end else begin
            o_copy_start <= w_start;
            o_copy_bank  <= w_bank_d;
            o_copy_mode  <= w_cmode_d;
            o_busy       <= (w_state_d != ST_SHOW);
            // Compare against the post-swap shown mode so a swap never looks like a change.
            r_mode_chg   <= (i_mode != w_show_mode_d);
            if (w_start) begin
                r_pend <= 1'b0;
            end else if ((r_state == ST_COPY) && w_mode_ne_copy) begin
                r_pend <= 1'b1;
            end else begin
                r_pend <= r_pend;
            end
            if (w_swap) begin
                r_show_bank <= o_copy_bank;
                r_show_mode <= o_copy_mode;
                r_have      <= 1'b1;
                r_w_disp    <= w_new_w;
                r_h_disp    <= w_new_h;
                r_xoff      <= (ADDR_W'(SCR_W) - w_new_w) >> 1'd1;
                r_yoff      <= (ADDR_W'(SCR_H) - w_new_h) >> 1'd1;
            end else begin
                r_show_bank <= r_show_bank;
                r_show_mode <= r_show_mode;
                r_have      <= r_have;
                r_w_disp    <= r_w_disp;
                r_h_disp    <= r_h_disp;
                r_xoff      <= r_xoff;
                r_yoff      <= r_yoff;
            end
        end
    end

    logic [ADDR_W-1:0] w_x, w_y;
    logic              w_in_img;
    logic [ADDR_W-1:0] r_s1_dx, r_s1_dy, r_s1_w;
    logic              r_s1_in, r_s1_bank, r_s1_have;

    assign w_x = ADDR_W'(i_next_x);
    assign w_y = ADDR_W'(i_next_y);
    assign w_in_img = (w_x >= r_xoff) && (w_x < (r_xoff + r_w_disp)) &&
                      (w_y >= r_yoff) && (w_y < (r_yoff + r_h_disp));

    // Two-stage address pipeline; bank, width and image flag travel with the pixel.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_dx     <= {ADDR_W{1'b0}};
            r_s1_dy     <= {ADDR_W{1'b0}};
            r_s1_w      <= {ADDR_W{1'b0}};
            r_s1_in     <= 1'b0;
            r_s1_bank   <= 1'b0;
            r_s1_have   <= 1'b0;
            o_rd_addr   <= {ADDR_W{1'b0}};
            o_rd_bank   <= 1'b0;
            o_pix_valid <= 1'b0;
        end else begin
            r_s1_dx     <= w_x - r_xoff;
            r_s1_dy     <= w_y - r_yoff;
            r_s1_w      <= r_w_disp;
            r_s1_in     <= w_in_img;
            r_s1_bank   <= r_show_bank;
            r_s1_have   <= r_have;
            o_rd_addr   <= r_s1_in ? ((r_s1_dy * r_s1_w) + r_s1_dx) : {ADDR_W{1'b0}};
            o_rd_bank   <= r_s1_bank;
            o_pix_valid <= r_s1_in & r_s1_have;
        end
    end

endmodule

// File: tb/tb_fb_scan_controller.sv
// Self-checking bench for fb_scan_controller (default build, watchdog off).
module tb_fb_scan_controller;
    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        next_x, next_y;
    logic              frame_start, copy_done;
    logic [3:0]        mode;
    logic              copy_start, copy_bank, rd_bank, pix_valid, busy, copy_err;
    logic [3:0]        copy_mode;
    logic [ADDR_W-1:0] rd_addr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fb_scan_controller dut (
        .i_clk(clk), .i_reset(reset), .i_next_x(next_x), .i_next_y(next_y),
        .i_frame_start(frame_start), .i_mode(mode), .i_copy_done(copy_done),
        .o_copy_start(copy_start), .o_copy_bank(copy_bank), .o_copy_mode(copy_mode),
        .o_rd_addr(rd_addr), .o_rd_bank(rd_bank), .o_pix_valid(pix_valid),
        .o_busy(busy), .o_copy_err(copy_err)
    );

    // Reference: pixel position inside the centred, scaled image.
    function automatic void model(input logic [3:0] m, input int x, input int y,
                                  output bit v, output int a);
        int f, wd, hd, xo, yo;
        bit zoom, reduce;
        f = m[3] ? 4 : 2;
        zoom   = (m == 4'b0000) || (m == 4'b1000) || (m == 4'b0010) || (m == 4'b1010);
        reduce = (m == 4'b0001) || (m == 4'b0011) || (m == 4'b1001) || (m == 4'b1011);
        if (zoom) begin wd = 160 * f; hd = 120 * f; end
        else if (reduce) begin wd = 160 / f; hd = 120 / f; end
        else begin wd = 160; hd = 120; end
        xo = (640 - wd) / 2;
        yo = (480 - hd) / 2;
        v = (x >= xo) && (x < xo + wd) && (y >= yo) && (y < yo + hd);
        a = v ? ((y - yo) * wd + (x - xo)) : 0;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_done();
        copy_done = 1'b1; step(); copy_done = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1; step(); frame_start = 1'b0;
    endtask

    task automatic wait_start(input int bound, output bit found);
        found = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (copy_start === 1'b1) begin found = 1'b1; break; end
            step();
        end
    endtask

    // Random scan stream against the model; 2-cycle latency handled by a queue.
    task automatic test_stream(input logic [3:0] shown, input bit have, input logic bank,
                               input int n, input string tag);
        bit qv[$]; int qa[$];
        bit v, ev; int a, ea, x, y;
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                ev = qv.pop_front(); ea = qa.pop_front();
                total++;
                if (pix_valid !== ev || (have && rd_addr !== ADDR_W'(ea)) || (have && rd_bank !== bank)) begin
                    bad++;
                    $display("FAIL %s idx=%0d got v=%0b a=%0d b=%0b want v=%0b a=%0d b=%0b",
                             tag, i - 2, pix_valid, rd_addr, rd_bank, ev, ea, bank);
                end
            end
            if (i < n) begin
                x = int'($urandom_range(0, 799));
                y = int'($urandom_range(0, 524));
                model(shown, x, y, v, a);
                qv.push_back(have ? v : 1'b0);
                qa.push_back(a);
                next_x = 10'(x); next_y = 10'(y);
            end
            step();
        end
    endtask

    // Two directed pixels, pipelined back to back.
    task automatic test_pixels(input int x0, input int y0, input int a0, input bit v0,
                               input int x1, input int y1, input int a1, input bit v1,
                               input string tag);
        next_x = 10'(x0); next_y = 10'(y0); step();
        next_x = 10'(x1); next_y = 10'(y1); step();
        total++;
        if (rd_addr !== ADDR_W'(a0) || pix_valid !== v0) begin
            bad++; $display("FAIL %s_a got a=%0d v=%0b want a=%0d v=%0b", tag, rd_addr, pix_valid, a0, v0);
        end
        step();
        total++;
        if (rd_addr !== ADDR_W'(a1) || pix_valid !== v1) begin
            bad++; $display("FAIL %s_b got a=%0d v=%0b want a=%0d v=%0b", tag, rd_addr, pix_valid, a1, v1);
        end
    endtask

    task automatic test_reset();
        logic [ADDR_W+9:0] outs;
        reset = 1'b1; mode = 4'b0000; copy_done = 1'b0; frame_start = 1'b0;
        next_x = 10'd0; next_y = 10'd0;
        repeat (3) step();
        outs = {copy_start, copy_bank, copy_mode, rd_addr, rd_bank, pix_valid, busy, copy_err};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL reset_outs got=%h want=0", outs); end
    endtask

    task automatic test_boot();
        reset = 1'b0;
        step();
        total++;
        if (copy_start !== 1'b1 || copy_bank !== 1'b0 || copy_mode !== 4'b0000 || busy !== 1'b1) begin
            bad++; $display("FAIL boot_start got s=%0b b=%0b m=%b busy=%0b want 1 0 0000 1",
                            copy_start, copy_bank, copy_mode, busy);
        end
        step();
        total++;
        if (copy_start !== 1'b0) begin bad++; $display("FAIL boot_pulse_width got=%0b want=0", copy_start); end
        test_stream(4'b0000, 1'b0, 1'b0, 20, "boot_copy_black");
        pulse_done();
        test_stream(4'b0000, 1'b0, 1'b0, 10, "boot_swapwait_black");
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL boot_busy_swapwait got=%0b want=1", busy); end
        pulse_frame();
        step();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL boot_busy_show got=%0b want=0", busy); end
    endtask

    task automatic test_addr_zoom2();
        test_pixels(161, 122, 641, 1'b1, 159, 122, 0, 1'b0, "zoom2_dir");
        test_stream(4'b0000, 1'b1, 1'b0, 60, "zoom2_rand");
    endtask

    task automatic test_swap_reduce4();
        bit found;
        mode = 4'b1001;
        wait_start(10, found);
        total++;
        if (!found || copy_bank !== 1'b1 || copy_mode !== 4'b1001) begin
            bad++; $display("FAIL swap_start got f=%0b b=%0b m=%b want 1 1 1001", found, copy_bank, copy_mode);
        end
        step();
        test_stream(4'b0000, 1'b1, 1'b0, 30, "swap_old_geom");
        copy_done = 1'b1; frame_start = 1'b1; step(); copy_done = 1'b0; frame_start = 1'b0;
        test_stream(4'b0000, 1'b1, 1'b0, 10, "swap_not_same_frame");
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL swap_busy_pending got=%0b want=1", busy); end
        pulse_frame();
        repeat (3) step();
        total++;
        if (rd_bank !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL swap_done got bank=%0b busy=%0b want 1 0", rd_bank, busy);
        end
        test_pixels(339, 254, 1199, 1'b1, 340, 254, 0, 1'b0, "reduce4_dir");
        test_stream(4'b1001, 1'b1, 1'b1, 60, "reduce4_rand");
    endtask

    task automatic test_ignored_in_show();
        bit seen;
        seen = 1'b0;
        pulse_done();
        pulse_frame();
        for (int k = 0; k < 6; k++) begin
            if (copy_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            step();
        end
        total++;
        if (seen || rd_bank !== 1'b1) begin
            bad++; $display("FAIL show_ignores got spurious=%0b bank=%0b want 0 1", seen, rd_bank);
        end
    endtask

    task automatic test_change_during_copy();
        bit found;
        mode = 4'b0000;
        wait_start(10, found);
        total++;
        if (!found || copy_bank !== 1'b0 || copy_mode !== 4'b0000) begin
            bad++; $display("FAIL chg_start1 got f=%0b b=%0b m=%b want 1 0 0000", found, copy_bank, copy_mode);
        end
        repeat (5) step();
        pulse_done();
        repeat (3) step();
        mode = 4'b0010;
        wait_start(5, found);
        total++;
        if (!found || copy_bank !== 1'b0 || copy_mode !== 4'b0010) begin
            bad++; $display("FAIL chg_abandon got f=%0b b=%0b m=%b want 1 0 0010", found, copy_bank, copy_mode);
        end
        repeat (4) step();
        mode = 4'b1000;
        test_stream(4'b1001, 1'b1, 1'b1, 8, "chg_still_old");
        pulse_done();
        wait_start(5, found);
        total++;
        if (!found || copy_bank !== 1'b0 || copy_mode !== 4'b1000) begin
            bad++; $display("FAIL chg_restart got f=%0b b=%0b m=%b want 1 0 1000", found, copy_bank, copy_mode);
        end
        repeat (4) step();
        pulse_done();
        repeat (3) step();
        total++;
        if (busy !== 1'b1 || rd_bank !== 1'b1) begin
            bad++; $display("FAIL chg_no_early_swap got busy=%0b bank=%0b want 1 1", busy, rd_bank);
        end
        pulse_frame();
        repeat (3) step();
        total++;
        if (busy !== 1'b0 || rd_bank !== 1'b0) begin
            bad++; $display("FAIL chg_swap got busy=%0b bank=%0b want 0 0", busy, rd_bank);
        end
        test_pixels(5, 3, 1925, 1'b1, 639, 479, 307199, 1'b1, "zoom4_dir");
        test_stream(4'b1000, 1'b1, 1'b0, 60, "zoom4_rand");
    endtask

    task automatic test_reset_midcopy();
        bit found;
        logic [ADDR_W+9:0] outs;
        mode = 4'b0011;
        wait_start(10, found);
        total++;
        if (!found || copy_bank !== 1'b1) begin
            bad++; $display("FAIL mid_start got f=%0b b=%0b want 1 1", found, copy_bank);
        end
        repeat (3) step();
        reset = 1'b1;
        step();
        outs = {copy_start, copy_bank, copy_mode, rd_addr, rd_bank, pix_valid, busy, copy_err};
        total++;
        if (outs !== '0) begin bad++; $display("FAIL mid_reset_outs got=%h want=0", outs); end
        mode = 4'b1010;
        step();
        reset = 1'b0;
        step();
        total++;
        if (copy_start !== 1'b1 || copy_bank !== 1'b0 || copy_mode !== 4'b1010) begin
            bad++; $display("FAIL mid_reboot got s=%0b b=%0b m=%b want 1 0 1010", copy_start, copy_bank, copy_mode);
        end
        step();
        test_stream(4'b1010, 1'b0, 1'b0, 15, "mid_black");
        pulse_done();
        pulse_frame();
        step();
        test_stream(4'b1010, 1'b1, 1'b0, 40, "mid_zoom4_rand");
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_boot();
        test_addr_zoom2();
        test_swap_reduce4();
        test_ignored_in_show();
        test_change_during_copy();
        test_reset_midcopy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
